// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial D = A - B - Bin, LSB first, one full-subtractor
// cell per clock with a registered borrow. Parallel operands in via
// start/busy/done, parallel difference and borrow-out back.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             bout
);

  // One extra counter bit so the count can reach WIDTH without wrapping.
  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             br_q, br_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic             bout_q, bout_d;

  logic             ai, bi;
  logic             diff_bit;
  logic             borrow_next;
  logic [WIDTH:0]   res_ext;

  // Single full-subtractor cell on the operand LSBs and the registered borrow.
  always_comb begin
    ai          = a_sh_q[0];
    bi          = b_sh_q[0];
    diff_bit    = ai ^ bi ^ br_q;
    borrow_next = (~ai & bi) | (~(ai ^ bi) & br_q);
    // Appending the new bit above the result and dropping the LSB also works for WIDTH=1.
    res_ext     = {diff_bit, res_q};
  end

  // Next-state and datapath control; every register holds unless its state acts on it.
  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    res_d   = res_q;
    br_d    = br_q;
    cnt_d   = cnt_q;
    d_d     = d_q;
    bout_d  = bout_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          br_d    = bin;
          res_d   = '0;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        res_d  = res_ext[WIDTH:1];
        a_sh_d = a_sh_q >> 1;
        b_sh_d = b_sh_q >> 1;
        br_d   = borrow_next;
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_BIT) begin
          // The visible result is only ever updated with a complete difference.
          d_d     = res_ext[WIDTH:1];
          bout_d  = borrow_next;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset that overrides any start.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      res_q   <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
      d_q     <= '0;
      bout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      res_q   <= res_d;
      br_q    <= br_d;
      cnt_q   <= cnt_d;
      d_q     <= d_d;
      bout_q  <= bout_d;
    end
  end

  // Handshake flags decode straight from the state register.
  always_comb begin
    busy = (state_q == SHIFT);
    done = (state_q == DONE);
    d    = d_q;
    bout = bout_q;
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed vector table, held-start, mid-operation reset
// and random regression for three instances (WIDTH = 8, 1, 13).
module tb_serial_subtractor;

  logic clk = 1'b0;
  logic rst;

  logic        st8, bi8, busy8, done8, bout8;
  logic [7:0]  a8, b8, d8;
  logic        st1, bi1, busy1, done1, bout1;
  logic [0:0]  a1, b1, d1;
  logic        st13, bi13, busy13, done13, bout13;
  logic [12:0] a13, b13, d13;

  int tests = 0;
  int failures = 0;

  typedef struct {
    int          inst;
    logic [15:0] a;
    logic [15:0] b;
    logic        bin;
    logic [15:0] exp_d;
    logic        exp_bout;
  } vec_t;

  vec_t vecs[12];

  serial_subtractor #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst(rst), .start(st8), .a(a8), .b(b8), .bin(bi8),
    .busy(busy8), .done(done8), .d(d8), .bout(bout8)
  );

  serial_subtractor #(.WIDTH(1)) u_w1 (
    .clk(clk), .rst(rst), .start(st1), .a(a1), .b(b1), .bin(bi1),
    .busy(busy1), .done(done1), .d(d1), .bout(bout1)
  );

  serial_subtractor #(.WIDTH(13)) u_w13 (
    .clk(clk), .rst(rst), .start(st13), .a(a13), .b(b13), .bin(bi13),
    .busy(busy13), .done(done13), .d(d13), .bout(bout13)
  );

  // Free-running clock, 10 ns period.
  always #5 clk = ~clk;

  // Hard stop in case something wedges the stimulus.
  initial begin
    #800000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic int instWidth(input int inst);
    case (inst)
      0:       return 8;
      1:       return 1;
      default: return 13;
    endcase
  endfunction

  // Modular reference: returns {bout, d} for the given width.
  function automatic logic [16:0] model(input int w, input logic [15:0] av,
                                        input logic [15:0] bv, input logic bi);
    int mask;
    int am;
    int bm;
    int diff;
    logic [16:0] r;
    mask = (1 << w) - 1;
    am = int'(av) & mask;
    bm = int'(bv) & mask;
    diff = am - bm - int'(bi);
    r[15:0] = 16'(diff & mask);
    r[16] = (am < bm + int'(bi));
    return r;
  endfunction

  task automatic drive(input int inst, input logic st, input logic [15:0] av,
                       input logic [15:0] bv, input logic bi);
    case (inst)
      0: begin st8 = st; a8 = av[7:0]; b8 = bv[7:0]; bi8 = bi; end
      1: begin st1 = st; a1 = av[0:0]; b1 = bv[0:0]; bi1 = bi; end
      default: begin st13 = st; a13 = av[12:0]; b13 = bv[12:0]; bi13 = bi; end
    endcase
  endtask

  task automatic sample(input int inst, output logic bz, output logic dn,
                        output logic [15:0] dv, output logic bo);
    case (inst)
      0: begin bz = busy8; dn = done8; dv = {8'h00, d8}; bo = bout8; end
      1: begin bz = busy1; dn = done1; dv = {15'h0000, d1}; bo = bout1; end
      default: begin bz = busy13; dn = done13; dv = {3'b000, d13}; bo = bout13; end
    endcase
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One full operation: pulse start, scramble operands, track busy/done timing and result.
  task automatic applyStimulus(input int inst, input logic [15:0] av,
                               input logic [15:0] bv, input logic bi,
                               input logic [15:0] exp_d, input logic exp_bo,
                               input string tag);
    int w;
    int cyc;
    int busy_cnt;
    logic got;
    logic stable;
    logic bz, dn, bo;
    logic [15:0] dv, prev_d;
    w = instWidth(inst);
    @(negedge clk);
    sample(inst, bz, dn, prev_d, bo);
    drive(inst, 1'b1, av, bv, bi);
    @(negedge clk);
    drive(inst, 1'b0, ~av, ~bv, ~bi);
    cyc = 1;
    busy_cnt = 0;
    got = 1'b0;
    stable = 1'b1;
    dv = '0;
    bo = 1'b0;
    while (!got && cyc <= w + 4) begin
      sample(inst, bz, dn, dv, bo);
      if (dn) begin
        got = 1'b1;
      end else begin
        if (bz) busy_cnt++;
        if (dv !== prev_d) stable = 1'b0;
        @(negedge clk);
        cyc++;
      end
    end
    checkOutput({tag, " done seen"}, 32'(got), 32'd1);
    checkOutput({tag, " busy cycles"}, 32'(busy_cnt), 32'(w));
    checkOutput({tag, " done cycle"}, 32'(cyc), 32'(w + 1));
    checkOutput({tag, " d"}, 32'(dv), 32'(exp_d));
    checkOutput({tag, " bout"}, 32'(bo), 32'(exp_bo));
    checkOutput({tag, " d held until done"}, 32'(stable), 32'd1);
  endtask

  initial begin
    logic bz, dn, bo;
    logic [15:0] dv;
    logic [15:0] ra, rb;
    logic rbi;
    logic [16:0] m;
    logic [15:0] ha[32];
    logic [15:0] hb[32];
    logic hbi[32];
    int phase;
    int errs_busy;
    int errs_done;
    int late_done;

    // Vector table: WIDTH=8 cases, then the complete WIDTH=1 truth table.
    vecs[0]  = '{0, 16'h05, 16'h03, 1'b0, 16'h02, 1'b0};
    vecs[1]  = '{0, 16'h03, 16'h05, 1'b0, 16'hFE, 1'b1};
    vecs[2]  = '{0, 16'h00, 16'h00, 1'b1, 16'hFF, 1'b1};
    vecs[3]  = '{0, 16'h80, 16'h01, 1'b0, 16'h7F, 1'b0};
    vecs[4]  = '{1, 16'h0, 16'h0, 1'b0, 16'h0, 1'b0};
    vecs[5]  = '{1, 16'h0, 16'h0, 1'b1, 16'h1, 1'b1};
    vecs[6]  = '{1, 16'h0, 16'h1, 1'b0, 16'h1, 1'b1};
    vecs[7]  = '{1, 16'h0, 16'h1, 1'b1, 16'h0, 1'b1};
    vecs[8]  = '{1, 16'h1, 16'h0, 1'b0, 16'h1, 1'b0};
    vecs[9]  = '{1, 16'h1, 16'h0, 1'b1, 16'h0, 1'b0};
    vecs[10] = '{1, 16'h1, 16'h1, 1'b0, 16'h0, 1'b0};
    vecs[11] = '{1, 16'h1, 16'h1, 1'b1, 16'h1, 1'b1};

    rst = 1'b1;
    drive(0, 1'b0, 16'h0, 16'h0, 1'b0);
    drive(1, 1'b0, 16'h0, 16'h0, 1'b0);
    drive(2, 1'b0, 16'h0, 16'h0, 1'b0);
    repeat (3) @(negedge clk);
    sample(0, bz, dn, dv, bo);
    checkOutput("reset busy", 32'(bz), 32'd0);
    checkOutput("reset done", 32'(dn), 32'd0);
    checkOutput("reset d", 32'(dv), 32'd0);
    checkOutput("reset bout", 32'(bo), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i].inst, vecs[i].a, vecs[i].b, vecs[i].bin,
                    vecs[i].exp_d, vecs[i].exp_bout, $sformatf("vec%0d", i));
    end

    // Start held high with operands changing every cycle: accepts every WIDTH+2 cycles.
    errs_busy = 0;
    errs_done = 0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      @(negedge clk);
      sample(0, bz, dn, dv, bo);
      phase = cyc % 10;
      if (bz !== (phase >= 1 && phase <= 8)) errs_busy++;
      if (dn !== (phase == 9)) errs_done++;
      if (phase == 9) begin
        m = model(8, ha[cyc - 9], hb[cyc - 9], hbi[cyc - 9]);
        checkOutput($sformatf("held op%0d d", cyc / 10), 32'(dv), 32'(m[15:0]));
        checkOutput($sformatf("held op%0d bout", cyc / 10), 32'(bo), 32'(m[16]));
      end
      ra = 16'($urandom);
      rb = 16'($urandom);
      rbi = 1'($urandom);
      ha[cyc] = ra;
      hb[cyc] = rb;
      hbi[cyc] = rbi;
      drive(0, 1'b1, ra, rb, rbi);
    end
    drive(0, 1'b0, 16'h0, 16'h0, 1'b0);
    checkOutput("held busy pattern errors", 32'(errs_busy), 32'd0);
    checkOutput("held done pattern errors", 32'(errs_done), 32'd0);

    // Reset in cycle 4 of an operation aborts it with no done pulse.
    @(negedge clk);
    drive(0, 1'b1, 16'hFF, 16'h01, 1'b0);
    @(negedge clk);
    drive(0, 1'b0, 16'h00, 16'h00, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    drive(0, 1'b1, 16'hFF, 16'h01, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    drive(0, 1'b0, 16'h00, 16'h00, 1'b0);
    sample(0, bz, dn, dv, bo);
    checkOutput("abort busy", 32'(bz), 32'd0);
    checkOutput("abort done", 32'(dn), 32'd0);
    checkOutput("abort d", 32'(dv), 32'd0);
    checkOutput("abort bout", 32'(bo), 32'd0);
    late_done = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      sample(0, bz, dn, dv, bo);
      if (dn || bz) late_done++;
    end
    checkOutput("abort no later activity", 32'(late_done), 32'd0);
    applyStimulus(0, 16'hFF, 16'h01, 1'b0, 16'hFE, 1'b0, "post-reset");

    // Random regression against the modular model for WIDTH=8 and WIDTH=13.
    for (int inst = 0; inst <= 2; inst += 2) begin
      for (int n = 0; n < 1000; n++) begin
        ra = 16'($urandom);
        rb = 16'($urandom);
        rbi = 1'($urandom);
        m = model(instWidth(inst), ra, rb, rbi);
        applyStimulus(inst, ra, rb, rbi, m[15:0], m[16],
                      $sformatf("rand w%0d #%0d", instWidth(inst), n));
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
Bit-serial multi-bit subtractor. It computes D = A - B - Bin over WIDTH cycles, LSB first, using a single full-subtractor cell and a registered borrow. It accepts parallel operands through a start/busy/done handshake and returns a parallel difference plus borrow-out. It is the sequential, multi-bit counterpart of the 1-bit full subtractor and reuses that cell's truth table per bit.

Parameters:
WIDTH, 8, operand and result width in bits (legal range >= 1)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
start  input  1  request; sampled only in IDLE
a  input  WIDTH  minuend; latched on accepted start
b  input  WIDTH  subtrahend; latched on accepted start
bin  input  1  borrow-in; latched on accepted start
busy  output  1  high while bits are being processed
done  output  1  one-cycle pulse; d/bout valid from this cycle
d  output  WIDTH  difference, registered
bout  output  1  final borrow-out, registered

Behaviour:
- One clock and one reset. Reset is synchronous and active-high; the ports are clk and rst.
- Reset (rst=1 at a clk edge):
  - state goes to IDLE.
  - busy=0, done=0, d=0, bout=0.
  - Internal shift registers, bit counter and borrow register clear.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - If start=1 at an edge, latch a, b and bin into operand shift registers and the borrow register.
  - Clear the bit counter and go to SHIFT.
  - Otherwise stay in IDLE.
- SHIFT, one bit per cycle:
  - ai and bi are the current LSBs of the operand shift registers; br is the registered borrow.
  - diff bit = ai ^ bi ^ br.
  - borrow next = (~ai & bi) | (~(ai ^ bi) & br).
  - Shift the diff bit into the result register from the MSB end. Shift both operand registers right. Increment the counter.
  - After the WIDTH-th bit is processed, go to DONE.
- DONE (one cycle):
  - On entry, copy the result register to d and the final borrow to bout.
  - done=1 this cycle; next state IDLE.
- busy=1 exactly while in SHIFT.
- Latency: start sampled at edge 0, busy high for cycles 1..WIDTH, done high in cycle WIDTH+1, new start accepted from cycle WIDTH+2.
- d/bout hold their value from the done cycle until the done of the next completed operation or a reset. They never show partial results.
- start is ignored in SHIFT and DONE; no queueing.
- a, b and bin may change freely after the accepting edge without affecting the result.
- Arithmetic: d = (a - b - bin) mod 2^WIDTH. bout=1 iff a < b + bin, compared as unsigned.
- WIDTH=1: one SHIFT cycle; the result equals the 1-bit full subtractor truth table.
- Reset mid-operation:
  - Aborts immediately and returns to IDLE with all outputs 0.
  - No done pulse for the aborted operation.
  - If rst and start are both high on the same edge, reset wins and start is dropped.
- Counter width is clog2(WIDTH)+1 so that WIDTH is reachable without wrap.

Test Plan:
- WIDTH=8, a=0x05, b=0x03, bin=0, start pulse -> busy for 8 cycles, done pulse at cycle 9, d=0x02, bout=0.
- WIDTH=8, a=0x03, b=0x05, bin=0 -> d=0xFE, bout=1. Then a=0x00, b=0x00, bin=1 -> d=0xFF, bout=1. Then a=0x80, b=0x01, bin=0 -> d=0x7F, bout=0.
- WIDTH=1, all 8 (a,b,bin) combinations 000..111 -> (d,bout) = 00, 11, 11, 01, 10, 00, 00, 11.
- WIDTH=8, start held high continuously with operands changing every cycle -> only the operands at the accepting edge are used. No start is accepted during busy or done. Back-to-back operations are spaced WIDTH+2 cycles apart.
- WIDTH=8, rst asserted in cycle 4 of an operation (a=0xFF, b=0x01) -> next cycle busy=0, done=0, d=0x00, bout=0, and no done pulse follows. A new start then completes correctly with d=0xFE, bout=0.
- Random regression: 1000 random a/b/bin for WIDTH=8 and WIDTH=13 -> d and bout match the modular reference model on every done pulse, and d stays stable between done pulses.
